// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: shared bundle layout, opcodes and halt FSM encoding for ctrl_pipe.
package ctrl_pipe_pkg;

    localparam int CTRL_W = 12;

    localparam int B_REGWRITE = 0;
    localparam int B_REGDST   = 1;
    localparam int B_ALUSRC   = 2;
    localparam int B_MEMREAD  = 3;
    localparam int B_MEMWRITE = 4;
    localparam int B_MEMTOREG = 5;
    localparam int B_LOWER    = 6;
    localparam int B_HIGHER   = 7;
    localparam int B_BEN      = 8;
    localparam int B_BR       = 9;
    localparam int B_PCS      = 10;
    localparam int B_HLT      = 11;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_XOR    = 4'd2;
    localparam logic [3:0] OP_RED    = 4'd3;
    localparam logic [3:0] OP_SLL    = 4'd4;
    localparam logic [3:0] OP_SRA    = 4'd5;
    localparam logic [3:0] OP_ROR    = 4'd6;
    localparam logic [3:0] OP_PADDSB = 4'd7;
    localparam logic [3:0] OP_LW     = 4'd8;
    localparam logic [3:0] OP_SW     = 4'd9;
    localparam logic [3:0] OP_LLB    = 4'd10;
    localparam logic [3:0] OP_LHB    = 4'd11;
    localparam logic [3:0] OP_B      = 4'd12;
    localparam logic [3:0] OP_BR     = 4'd13;
    localparam logic [3:0] OP_PCS    = 4'd14;
    localparam logic [3:0] OP_HLT    = 4'd15;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PEND   = 2'd1,
        HALTED = 2'd2
    } halt_st_t;

endpackage

// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if: ID-side inputs and per-stage control outputs of ctrl_pipe.
interface ctrl_pipe_if #(
    parameter int REG_AW = 4
);
    import ctrl_pipe_pkg::*;

    logic              instr_valid;
    logic [3:0]        opc;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic              ext_stall;
    logic              flush;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CTRL_W-1:0] mem_ctrl;
    logic [CTRL_W-1:0] wb_ctrl;
    logic [REG_AW-1:0] ex_rd;
    logic [REG_AW-1:0] mem_rd;
    logic [REG_AW-1:0] wb_rd;
    logic              fetch_hold;
    logic              load_use;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              halted;

    modport master (
        output instr_valid, opc, id_rs, id_rt, id_rd, ext_stall, flush,
        input  ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd,
        input  fetch_hold, load_use, fwd_a, fwd_b, halted
    );

    modport slave (
        input  instr_valid, opc, id_rs, id_rt, id_rd, ext_stall, flush,
        output ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd,
        output fetch_hold, load_use, fwd_a, fwd_b, halted
    );

endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: opcode to control bundle plus which register sources the instruction reads.
module ctrl_decode
    import ctrl_pipe_pkg::*;
#(
    parameter int REG_AW       = 4,
    parameter bit R0_HARDWIRED = 1'b1
) (
    input  logic              instr_valid,
    input  logic [3:0]        opc,
    input  logic [REG_AW-1:0] rd,
    output logic [CTRL_W-1:0] ctrl,
    output logic              use_rs,
    output logic              use_rt
);

    logic [CTRL_W-1:0] raw;

    // raw bundle per opcode class, before validity and r0 write suppression
    always_comb begin
        raw = '0;
        case (opc)
            OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: begin
                raw[B_REGWRITE] = 1'b1;
                raw[B_REGDST]   = 1'b1;
            end
            OP_SLL, OP_SRA, OP_ROR: begin
                raw[B_REGWRITE] = 1'b1;
                raw[B_REGDST]   = 1'b1;
                raw[B_ALUSRC]   = 1'b1;
            end
            OP_LW: begin
                raw[B_REGWRITE] = 1'b1;
                raw[B_ALUSRC]   = 1'b1;
                raw[B_MEMREAD]  = 1'b1;
                raw[B_MEMTOREG] = 1'b1;
            end
            OP_SW: begin
                raw[B_ALUSRC]   = 1'b1;
                raw[B_MEMWRITE] = 1'b1;
            end
            OP_LLB: begin
                raw[B_REGWRITE] = 1'b1;
                raw[B_REGDST]   = 1'b1;
                raw[B_ALUSRC]   = 1'b1;
                raw[B_LOWER]    = 1'b1;
            end
            OP_LHB: begin
                raw[B_REGWRITE] = 1'b1;
                raw[B_REGDST]   = 1'b1;
                raw[B_ALUSRC]   = 1'b1;
                raw[B_HIGHER]   = 1'b1;
            end
            OP_B:   raw[B_BEN] = 1'b1;
            OP_BR:  raw[B_BR]  = 1'b1;
            OP_PCS: begin
                raw[B_REGWRITE] = 1'b1;
                raw[B_REGDST]   = 1'b1;
                raw[B_PCS]      = 1'b1;
            end
            default: raw[B_HLT] = 1'b1;
        endcase
    end

    // gate by validity, drop writes to r0, and flag the sources read
    always_comb begin
        ctrl = instr_valid ? raw : '0;
        if (R0_HARDWIRED && rd == '0) ctrl[B_REGWRITE] = 1'b0;
        use_rs = instr_valid && (opc <= OP_LHB || opc == OP_BR);
        use_rt = instr_valid && (opc <= OP_RED || opc == OP_PADDSB || opc == OP_SW);
    end

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined control with load-use bubbles, branch flush and HLT sequencing.
// Define CTRL_PIPE_FWD_EN to enable EX operand forwarding selects.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int REG_AW       = 4,
    parameter bit R0_HARDWIRED = 1'b1
) (
    input logic        clk,
    input logic        rst,
    ctrl_pipe_if.slave bus
);

    logic [CTRL_W-1:0] dec_ctrl;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CTRL_W-1:0] mem_ctrl;
    logic [CTRL_W-1:0] wb_ctrl;
    logic [REG_AW-1:0] ex_rd;
    logic [REG_AW-1:0] mem_rd;
    logic [REG_AW-1:0] wb_rd;
    logic              use_rs;
    logic              use_rt;
    logic              load_use;
    logic              bubble;
    halt_st_t          state;
    halt_st_t          state_nxt;

    function automatic logic hit(input logic wr, input logic [REG_AW-1:0] dst,
                                 input logic [REG_AW-1:0] src);
        return wr && dst == src && !(R0_HARDWIRED && dst == '0);
    endfunction

    ctrl_decode #(
        .REG_AW      (REG_AW),
        .R0_HARDWIRED(R0_HARDWIRED)
    ) u_decode (
        .instr_valid(bus.instr_valid),
        .opc        (bus.opc),
        .rd         (bus.id_rd),
        .ctrl       (dec_ctrl),
        .use_rs     (use_rs),
        .use_rt     (use_rt)
    );

`ifdef CTRL_PIPE_FWD_EN
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;

    // with forwarding only a load in EX can leave an ID source unresolved
    always_comb begin
        load_use = (use_rs && hit(ex_ctrl[B_MEMREAD], ex_rd, bus.id_rs))
                || (use_rt && hit(ex_ctrl[B_MEMREAD], ex_rd, bus.id_rt));
    end

    // source addresses ride with ID/EX so EX can choose a forward path
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_rs <= '0;
            ex_rt <= '0;
        end else if (!bus.ext_stall) begin
            ex_rs <= bubble ? '0 : bus.id_rs;
            ex_rt <= bubble ? '0 : bus.id_rt;
        end
    end

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
        return hit(mem_ctrl[B_REGWRITE], mem_rd, src) ? 2'b10 :
               hit(wb_ctrl[B_REGWRITE], wb_rd, src)   ? 2'b01 : 2'b00;
    endfunction

    assign bus.fwd_a = fwd_sel(ex_rs);
    assign bus.fwd_b = fwd_sel(ex_rt);
`else
    // without forwarding any writer still in EX or EX/MEM blocks the reader
    always_comb begin
        load_use = (use_rs && (hit(ex_ctrl[B_MEMREAD], ex_rd, bus.id_rs)
                            || hit(ex_ctrl[B_REGWRITE], ex_rd, bus.id_rs)
                            || hit(mem_ctrl[B_REGWRITE], mem_rd, bus.id_rs)))
                || (use_rt && (hit(ex_ctrl[B_MEMREAD], ex_rd, bus.id_rt)
                            || hit(ex_ctrl[B_REGWRITE], ex_rd, bus.id_rt)
                            || hit(mem_ctrl[B_REGWRITE], mem_rd, bus.id_rt)));
    end

    assign bus.fwd_a = 2'b00;
    assign bus.fwd_b = 2'b00;
`endif

    assign bubble = bus.flush || load_use || state != RUN;

    // stage registers: ID/EX takes a bubble or the decode, later stages shift; all freeze on stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_ctrl  <= '0;
            mem_ctrl <= '0;
            wb_ctrl  <= '0;
            ex_rd    <= '0;
            mem_rd   <= '0;
            wb_rd    <= '0;
        end else if (!bus.ext_stall) begin
            ex_ctrl  <= bubble ? '0 : dec_ctrl;
            ex_rd    <= bubble ? '0 : bus.id_rd;
            mem_ctrl <= ex_ctrl;
            mem_rd   <= ex_rd;
            wb_ctrl  <= mem_ctrl;
            wb_rd    <= mem_rd;
        end
    end

    // halt state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // an issued HLT parks the front end until it reaches WB, then halt sticks
    always_comb begin
        state_nxt = state;
        if (!bus.ext_stall) begin
            state_nxt = (state == RUN && !bubble && dec_ctrl[B_HLT]) ? PEND :
                        (state == PEND && wb_ctrl[B_HLT])            ? HALTED : state;
        end
    end

    assign bus.ex_ctrl    = ex_ctrl;
    assign bus.mem_ctrl   = mem_ctrl;
    assign bus.wb_ctrl    = wb_ctrl;
    assign bus.ex_rd      = ex_rd;
    assign bus.mem_rd     = mem_rd;
    assign bus.wb_rd      = wb_rd;
    assign bus.load_use   = load_use;
    assign bus.fetch_hold = bus.ext_stall || load_use || state != RUN;
    assign bus.halted     = state == HALTED;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed and random stimulus for ctrl_pipe checked against a queue-based model.
module tb_ctrl_pipe;

    localparam int AW = 4;
`ifdef CTRL_PIPE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic [11:0] c;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [3:0]  rt;
    } ins_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    ins_t pipe[$];
    bit   m_pend;
    bit   m_halted;
    logic exp_lu;
    logic exp_fh;
    logic [1:0] exp_fa;
    logic [1:0] exp_fb;

    always #5 clk = ~clk;

    ctrl_pipe_if #(.REG_AW(AW)) bus ();

    ctrl_pipe #(.REG_AW(AW), .R0_HARDWIRED(1'b1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [11:0] ref_dec(logic v, logic [3:0] op, logic [3:0] rd);
        logic [11:0] c;
        if (!v) return 12'h000;
        if (op <= 3 || op == 7) c = 12'h003;
        else if (op <= 6)       c = 12'h007;
        else if (op == 8)       c = 12'h02D;
        else if (op == 9)       c = 12'h014;
        else if (op == 10)      c = 12'h047;
        else if (op == 11)      c = 12'h087;
        else if (op == 12)      c = 12'h100;
        else if (op == 13)      c = 12'h200;
        else if (op == 14)      c = 12'h403;
        else                    c = 12'h800;
        if (rd == 0) c[0] = 1'b0;
        return c;
    endfunction

    function automatic bit blocks(logic [3:0] r);
        bit ld = pipe[0].c[3] && pipe[0].rd == r && r != 0;
        bit w_ex = pipe[0].c[0] && pipe[0].rd == r && r != 0;
        bit w_mem = pipe[1].c[0] && pipe[1].rd == r && r != 0;
        return ld || (!FWD && (w_ex || w_mem));
    endfunction

    function automatic logic [1:0] ref_fwd(logic [3:0] src);
        if (!FWD) return 2'b00;
        if (pipe[1].c[0] && pipe[1].rd == src) return 2'b10;
        if (pipe[2].c[0] && pipe[2].rd == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_comb();
        logic [3:0] op = bus.opc;
        bit ur = bus.instr_valid && (op <= 11 || op == 13);
        bit ut = bus.instr_valid && (op <= 3 || op == 7 || op == 9);
        exp_lu = (ur && blocks(bus.id_rs)) || (ut && blocks(bus.id_rt));
        exp_fh = bus.ext_stall || exp_lu || m_pend || m_halted;
        exp_fa = ref_fwd(pipe[0].rs);
        exp_fb = ref_fwd(pipe[0].rt);
    endtask

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("ex_ctrl", 16'(bus.ex_ctrl), 16'(pipe[0].c));
        chk("mem_ctrl", 16'(bus.mem_ctrl), 16'(pipe[1].c));
        chk("wb_ctrl", 16'(bus.wb_ctrl), 16'(pipe[2].c));
        chk("ex_rd", 16'(bus.ex_rd), 16'(pipe[0].rd));
        chk("mem_rd", 16'(bus.mem_rd), 16'(pipe[1].rd));
        chk("wb_rd", 16'(bus.wb_rd), 16'(pipe[2].rd));
        chk("load_use", 16'(bus.load_use), 16'(exp_lu));
        chk("fetch_hold", 16'(bus.fetch_hold), 16'(exp_fh));
        chk("fwd_a", 16'(bus.fwd_a), 16'(exp_fa));
        chk("fwd_b", 16'(bus.fwd_b), 16'(exp_fb));
        chk("halted", 16'(bus.halted), 16'(m_halted));
    endtask

    task automatic drive(logic v, logic [3:0] op, logic [3:0] rs, logic [3:0] rt,
                         logic [3:0] rd, logic st, logic fl);
        @(negedge clk);
        bus.instr_valid = v;
        bus.opc = op;
        bus.id_rs = rs;
        bus.id_rt = rt;
        bus.id_rd = rd;
        bus.ext_stall = st;
        bus.flush = fl;
        #1;
        model_comb();
        check_all();
    endtask

    task automatic tick();
        ins_t n;
        bit kill;
        @(posedge clk);
        if (!bus.ext_stall) begin
            kill = bus.flush || exp_lu || m_pend || m_halted;
            n.c  = kill ? 12'h000 : ref_dec(bus.instr_valid, bus.opc, bus.id_rd);
            n.rd = kill ? 4'h0 : bus.id_rd;
            n.rs = kill ? 4'h0 : bus.id_rs;
            n.rt = kill ? 4'h0 : bus.id_rt;
            if (m_pend && pipe[2].c[11]) begin
                m_pend = 1'b0;
                m_halted = 1'b1;
            end
            if (n.c[11]) m_pend = 1'b1;
            pipe.push_front(n);
            void'(pipe.pop_back());
        end
    endtask

    task automatic step(logic v, logic [3:0] op, logic [3:0] rs, logic [3:0] rt,
                        logic [3:0] rd, logic st, logic fl);
        drive(v, op, rs, rt, rd, st, fl);
        tick();
    endtask

    task automatic nop(int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.instr_valid = 1'b0;
        bus.opc = 4'h0;
        bus.id_rs = 4'h0;
        bus.id_rt = 4'h0;
        bus.id_rd = 4'h0;
        bus.ext_stall = 1'b0;
        bus.flush = 1'b0;
        pipe.delete();
        repeat (3) pipe.push_back('{c: 12'h000, rd: 4'h0, rs: 4'h0, rt: 4'h0});
        m_pend = 1'b0;
        m_halted = 1'b0;
        #1;
        model_comb();
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] op;
        do_reset();
        nop(1);

        // LW r3 then ADD r5,r3,r4: one bubble at least, then ADD issues
        step(1'b1, 4'd8, 4'd1, 4'd0, 4'd3, 1'b0, 1'b0);
        drive(1'b1, 4'd0, 4'd3, 4'd4, 4'd5, 1'b0, 1'b0);
        chk("lw_use_stall", 16'(bus.load_use), 16'h1);
        chk("lw_use_hold", 16'(bus.fetch_hold), 16'h1);
        tick();
        drive(1'b1, 4'd0, 4'd3, 4'd4, 4'd5, 1'b0, 1'b0);
        chk("lw_use_bubble", 16'(bus.ex_ctrl), 16'h0);
        tick();
        step(1'b1, 4'd0, 4'd3, 4'd4, 4'd5, 1'b0, 1'b0);
        nop(4);

        // ADD r2 then SW reading r2 as rt
        step(1'b1, 4'd0, 4'd1, 4'd1, 4'd2, 1'b0, 1'b0);
        step(1'b1, 4'd9, 4'd1, 4'd2, 4'd0, 1'b0, 1'b0);
        step(1'b1, 4'd9, 4'd1, 4'd2, 4'd0, 1'b0, 1'b0);
        step(1'b1, 4'd9, 4'd1, 4'd2, 4'd0, 1'b0, 1'b0);
        nop(4);

        // LW r0 then ADD r1,r0,r0: no hazard, write to r0 suppressed
        step(1'b1, 4'd8, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0);
        drive(1'b1, 4'd0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0);
        chk("r0_no_stall", 16'(bus.load_use), 16'h0);
        tick();
        nop(1);
        drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        chk("r0_lw_wb", 16'(bus.wb_ctrl), 16'h02C);
        tick();
        nop(3);

        // flushed HLT never issues
        step(1'b1, 4'd15, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
        drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        chk("flush_hlt_ex", 16'(bus.ex_ctrl), 16'h0);
        tick();
        nop(4);
        drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        chk("flush_hlt_run", 16'(bus.fetch_hold), 16'h0);
        tick();

        // HLT followed by ADD: hold from PEND, halt three clocks after HLT leaves ID
        step(1'b1, 4'd15, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        drive(1'b1, 4'd0, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0);
        chk("hlt_hold", 16'(bus.fetch_hold), 16'h1);
        tick();
        step(1'b1, 4'd0, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0);
        drive(1'b1, 4'd0, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0);
        chk("hlt_not_yet", 16'(bus.halted), 16'h0);
        tick();
        drive(1'b1, 4'd0, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0);
        chk("hlt_halted", 16'(bus.halted), 16'h1);
        tick();
        nop(2);
        drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        chk("hlt_sticky", 16'(bus.halted), 16'h1);
        tick();

        // reset with HLT sitting in MEM/WB clears everything at once
        do_reset();
        step(1'b1, 4'd15, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        nop(2);
        do_reset();
        chk("rst_wb", 16'(bus.wb_ctrl), 16'h0);
        chk("rst_hold", 16'(bus.fetch_hold), 16'h0);

        // two stall cycles in flight delay halt by exactly two clocks
        step(1'b1, 4'd15, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        step(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        step(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        nop(2);
        drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        chk("stall_hlt_late", 16'(bus.halted), 16'h0);
        tick();
        drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        chk("stall_hlt_on", 16'(bus.halted), 16'h1);
        tick();

        // random traffic with small register space to provoke hazards
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < 300; i++) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'd15 && $urandom_range(0, 39) != 0) op = 4'($urandom_range(0, 14));
                step($urandom_range(0, 9) != 0, op, 4'($urandom_range(0, 3)),
                     4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                     $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
